// File: rtl/rv64g_l2_pkg.sv
// ---------------------------------------------------------------------------
// rv64g_l2_pkg
// Shared definitions for the burst-capable L2 data/tag array block:
//   - default geometry constants (sets, ways, words per line, widths)
//   - request opcode encoding seen on req_op_i
//   - controller state encoding
// ---------------------------------------------------------------------------
package rv64g_l2_pkg;

  localparam int unsigned L2_SETS   = 256;
  localparam int unsigned L2_WAYS   = 16;
  localparam int unsigned L2_WORDS  = 8;
  localparam int unsigned L2_DATA_W = 64;
  localparam int unsigned L2_TAG_W  = 50;

  typedef enum logic [1:0] {
    OP_RD   = 2'd0,
    OP_WR   = 2'd1,
    OP_LINE = 2'd2,
    OP_INV  = 2'd3
  } l2_arr_op_e;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    IDLE  = 2'd1,
    BURST = 2'd2
  } l2_arr_state_e;

endpackage

// File: rtl/rv64g_l2_way_ram.sv
// ---------------------------------------------------------------------------
// rv64g_l2_way_ram
// Storage for a single way: data words, one tag per set and one valid bit per
// set.
//   clk             clock
//   rd_en           capture {rd_idx, rd_word} word, tag and valid of rd_idx
//   rd_idx/rd_word  read address
//   rd_data/rd_tag/rd_vld  registered read results; hold until next rd_en
//   wr_en           byte-masked data write at {wr_idx, wr_word}
//   wr_be/wr_data   byte enables and write data
//   tag_we/wr_tag   with wr_en: write the tag of wr_idx and set its valid bit
//   vld_clr/clr_idx clear the valid bit of clr_idx (wins over a set)
// ---------------------------------------------------------------------------
module rv64g_l2_way_ram
  import rv64g_l2_pkg::*;
#(
  parameter int SETS   = L2_SETS,
  parameter int WORDS  = L2_WORDS,
  parameter int DATA_W = L2_DATA_W,
  parameter int TAG_W  = L2_TAG_W,
  localparam int IDX_W  = $clog2(SETS),
  localparam int WSEL_W = $clog2(WORDS),
  localparam int BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rd_en,
  input  logic [IDX_W-1:0]  rd_idx,
  input  logic [WSEL_W-1:0] rd_word,
  output logic [DATA_W-1:0] rd_data,
  output logic [TAG_W-1:0]  rd_tag,
  output logic              rd_vld,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [WSEL_W-1:0] wr_word,
  input  logic [BE_W-1:0]   wr_be,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              tag_we,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic              vld_clr,
  input  logic [IDX_W-1:0]  clr_idx
);

  logic [DATA_W-1:0] data_mem [SETS*WORDS];
  logic [TAG_W-1:0]  tag_mem  [SETS];
  logic [SETS-1:0]   vld_q;

  logic [IDX_W+WSEL_W-1:0] rd_addr;
  logic [IDX_W+WSEL_W-1:0] wr_addr;

  assign rd_addr = {rd_idx, rd_word};
  assign wr_addr = {wr_idx, wr_word};

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < BE_W; b++) begin
        if (wr_be[b]) data_mem[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
      if (tag_we) tag_mem[wr_idx] <= wr_tag;
    end
  end

  // Valid bits are not reset here; the owner sweeps them clear after reset.
  always_ff @(posedge clk) begin
    if (vld_clr) begin
      vld_q[clr_idx] <= 1'b0;
    end else if (wr_en && tag_we) begin
      vld_q[wr_idx] <= 1'b1;
    end
  end

  // Read registers only update on rd_en so a stalled response stays stable.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= data_mem[rd_addr];
      rd_tag  <= tag_mem[rd_idx];
      rd_vld  <= vld_q[rd_idx];
    end
  end

endmodule

// File: rtl/rv64g_l2_arrays_burst.sv
// ---------------------------------------------------------------------------
// rv64g_l2_arrays_burst
// L2 data/tag arrays behind a valid/ready request and response interface.
// Supports word read, byte-masked write (optionally with tag + valid set),
// valid invalidate, and a full-line burst read. After reset the valid bits of
// every set are swept clear before requests are accepted.
//   clk_i, rst_i         clock, synchronous active-high reset
//   init_busy_o          valid-clear sweep in progress
//   req_valid_i/req_ready_o  request handshake
//   req_op_i             OP_RD / OP_WR / OP_LINE / OP_INV
//   req_index_i, req_way_i, req_word_i  location
//   req_be_i, req_wdata_i, req_tag_we_i, req_tag_i  write payload
//   rsp_valid_o/rsp_ready_i  response handshake (single-entry output slot)
//   rsp_rdata_o          selected word or burst beat
//   rsp_tag_o            tag of the addressed way
//   rsp_tag_way_flat_o   all tags of the set, way w at [w*TAG_W +: TAG_W]
//   rsp_vld_way_o        valid bits of the set
//   rsp_beat_o, rsp_last_o  beat number and final-beat flag
// ---------------------------------------------------------------------------
module rv64g_l2_arrays_burst
  import rv64g_l2_pkg::*;
#(
  parameter int SETS   = L2_SETS,
  parameter int WAYS   = L2_WAYS,
  parameter int WORDS  = L2_WORDS,
  parameter int DATA_W = L2_DATA_W,
  parameter int TAG_W  = L2_TAG_W,
  localparam int IDX_W  = $clog2(SETS),
  localparam int WAY_W  = $clog2(WAYS),
  localparam int WSEL_W = $clog2(WORDS),
  localparam int BE_W   = DATA_W / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  output logic                  init_busy_o,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [1:0]            req_op_i,
  input  logic [IDX_W-1:0]      req_index_i,
  input  logic [WAY_W-1:0]      req_way_i,
  input  logic [WSEL_W-1:0]     req_word_i,
  input  logic [BE_W-1:0]       req_be_i,
  input  logic [DATA_W-1:0]     req_wdata_i,
  input  logic                  req_tag_we_i,
  input  logic [TAG_W-1:0]      req_tag_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_W-1:0]     rsp_rdata_o,
  output logic [TAG_W-1:0]      rsp_tag_o,
  output logic [WAYS*TAG_W-1:0] rsp_tag_way_flat_o,
  output logic [WAYS-1:0]       rsp_vld_way_o,
  output logic [WSEL_W-1:0]     rsp_beat_o,
  output logic                  rsp_last_o
);

  l2_arr_state_e state_q;
  l2_arr_op_e    req_op;

  logic [IDX_W-1:0]  sweep_q;
  logic [IDX_W-1:0]  line_idx_q;
  logic [WAY_W-1:0]  line_way_q;
  logic [WSEL_W-1:0] beat_cnt_q;

  logic              rsp_vld_p1;
  logic              rsp_last_p1;
  logic [WAY_W-1:0]  rsp_way_p1;
  logic [WSEL_W-1:0] rsp_beat_p1;

  logic slot_free;
  logic accept;

  logic              ram_rd_en;
  logic [IDX_W-1:0]  ram_rd_idx;
  logic [WSEL_W-1:0] ram_rd_word;
  logic              ram_wr_en;
  logic              inv_en;
  logic              sweep_en;
  logic [IDX_W-1:0]  clr_idx;

  logic [DATA_W-1:0]     way_rdata [WAYS];
  logic [TAG_W-1:0]      way_rtag  [WAYS];
  logic [WAYS-1:0]       way_rvld;
  logic [WAYS*TAG_W-1:0] tag_flat;

  assign req_op = l2_arr_op_e'(req_op_i);

  // The output slot can take a new entry when empty or drained this cycle.
  assign slot_free   = !rsp_vld_p1 || rsp_ready_i;
  assign req_ready_o = (state_q == IDLE) && slot_free;
  assign accept      = req_valid_i && req_ready_o;
  assign init_busy_o = (state_q == INIT);

  // Stage p0: array access (read capture, write, valid clear) on this edge.
  always_comb begin
    ram_rd_en   = 1'b0;
    ram_rd_idx  = req_index_i;
    ram_rd_word = req_word_i;
    ram_wr_en   = 1'b0;
    inv_en      = 1'b0;
    sweep_en    = 1'b0;
    if (!rst_i) begin
      case (state_q)
        INIT: sweep_en = 1'b1;
        IDLE: begin
          if (accept) begin
            case (req_op)
              OP_RD:   ram_rd_en = 1'b1;
              OP_WR:   ram_wr_en = 1'b1;
              OP_INV:  inv_en    = 1'b1;
              default: ;
            endcase
          end
        end
        BURST: begin
          if (slot_free) begin
            ram_rd_en   = 1'b1;
            ram_rd_idx  = line_idx_q;
            ram_rd_word = beat_cnt_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign clr_idx = sweep_en ? sweep_q : req_index_i;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    logic sel;
    assign sel = (req_way_i == WAY_W'(w));

    rv64g_l2_way_ram #(
      .SETS   (SETS),
      .WORDS  (WORDS),
      .DATA_W (DATA_W),
      .TAG_W  (TAG_W)
    ) u_way (
      .clk     (clk_i),
      .rd_en   (ram_rd_en),
      .rd_idx  (ram_rd_idx),
      .rd_word (ram_rd_word),
      .rd_data (way_rdata[w]),
      .rd_tag  (way_rtag[w]),
      .rd_vld  (way_rvld[w]),
      .wr_en   (ram_wr_en && sel),
      .wr_idx  (req_index_i),
      .wr_word (req_word_i),
      .wr_be   (req_be_i),
      .wr_data (req_wdata_i),
      .tag_we  (req_tag_we_i),
      .wr_tag  (req_tag_i),
      .vld_clr (sweep_en || (inv_en && sel)),
      .clr_idx (clr_idx)
    );

    assign tag_flat[w*TAG_W +: TAG_W] = way_rtag[w];
  end

  // Stage p1: control state and output-slot bookkeeping.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= INIT;
      sweep_q     <= '0;
      beat_cnt_q  <= '0;
      rsp_vld_p1  <= 1'b0;
      rsp_last_p1 <= 1'b0;
      rsp_beat_p1 <= '0;
      rsp_way_p1  <= '0;
    end else begin
      if (rsp_vld_p1 && rsp_ready_i) rsp_vld_p1 <= 1'b0;
      case (state_q)
        INIT: begin
          sweep_q <= sweep_q + 1'b1;
          if (sweep_q == IDX_W'(SETS - 1)) state_q <= IDLE;
        end
        IDLE: begin
          if (accept) begin
            case (req_op)
              OP_RD: begin
                rsp_vld_p1  <= 1'b1;
                rsp_beat_p1 <= '0;
                rsp_last_p1 <= 1'b1;
                rsp_way_p1  <= req_way_i;
              end
              OP_LINE: begin
                state_q    <= BURST;
                beat_cnt_q <= '0;
              end
              default: ;
            endcase
          end
        end
        BURST: begin
          if (slot_free) begin
            rsp_vld_p1  <= 1'b1;
            rsp_beat_p1 <= beat_cnt_q;
            rsp_last_p1 <= (beat_cnt_q == WSEL_W'(WORDS - 1));
            rsp_way_p1  <= line_way_q;
            beat_cnt_q  <= beat_cnt_q + 1'b1;
            // Leaving on the last issue lets a new request in next cycle.
            if (beat_cnt_q == WSEL_W'(WORDS - 1)) state_q <= IDLE;
          end
        end
        default: state_q <= INIT;
      endcase
    end
  end

  // Burst location is pure data; it is only meaningful while in BURST.
  always_ff @(posedge clk_i) begin
    if (state_q == IDLE && accept && req_op == OP_LINE) begin
      line_idx_q <= req_index_i;
      line_way_q <= req_way_i;
    end
  end

  // Response payload comes straight from the way read registers, which hold
  // while the slot is stalled; an empty slot presents zeros.
  assign rsp_valid_o        = rsp_vld_p1;
  assign rsp_rdata_o        = rsp_vld_p1 ? way_rdata[rsp_way_p1] : '0;
  assign rsp_tag_o          = rsp_vld_p1 ? way_rtag[rsp_way_p1] : '0;
  assign rsp_tag_way_flat_o = rsp_vld_p1 ? tag_flat : '0;
  assign rsp_vld_way_o      = rsp_vld_p1 ? way_rvld : '0;
  assign rsp_beat_o         = rsp_beat_p1;
  assign rsp_last_o         = rsp_last_p1;

endmodule

// File: tb/tb_rv64g_l2_arrays_burst.sv
module tb_rv64g_l2_arrays_burst;
  import rv64g_l2_pkg::*;

  localparam int SETS = 256, WAYS = 16, WORDS = 8, DATA_W = 64, TAG_W = 50;
  localparam int IDX_W = 8, WAY_W = 4, WSEL_W = 3, BE_W = 8;

  logic                  clk_i = 1'b0;
  logic                  rst_i;
  logic                  init_busy_o;
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic [1:0]            req_op_i;
  logic [IDX_W-1:0]      req_index_i;
  logic [WAY_W-1:0]      req_way_i;
  logic [WSEL_W-1:0]     req_word_i;
  logic [BE_W-1:0]       req_be_i;
  logic [DATA_W-1:0]     req_wdata_i;
  logic                  req_tag_we_i;
  logic [TAG_W-1:0]      req_tag_i;
  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [DATA_W-1:0]     rsp_rdata_o;
  logic [TAG_W-1:0]      rsp_tag_o;
  logic [WAYS*TAG_W-1:0] rsp_tag_way_flat_o;
  logic [WAYS-1:0]       rsp_vld_way_o;
  logic [WSEL_W-1:0]     rsp_beat_o;
  logic                  rsp_last_o;

  rv64g_l2_arrays_burst dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .init_busy_o        (init_busy_o),
    .req_valid_i        (req_valid_i),
    .req_ready_o        (req_ready_o),
    .req_op_i           (req_op_i),
    .req_index_i        (req_index_i),
    .req_way_i          (req_way_i),
    .req_word_i         (req_word_i),
    .req_be_i           (req_be_i),
    .req_wdata_i        (req_wdata_i),
    .req_tag_we_i       (req_tag_we_i),
    .req_tag_i          (req_tag_i),
    .rsp_valid_o        (rsp_valid_o),
    .rsp_ready_i        (rsp_ready_i),
    .rsp_rdata_o        (rsp_rdata_o),
    .rsp_tag_o          (rsp_tag_o),
    .rsp_tag_way_flat_o (rsp_tag_way_flat_o),
    .rsp_vld_way_o      (rsp_vld_way_o),
    .rsp_beat_o         (rsp_beat_o),
    .rsp_last_o         (rsp_last_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int total = 0;
  int bad   = 0;

  // Reference model: contents as the user sees them, by (set, way, word).
  logic [63:0] m_data [int];
  logic [7:0]  m_bm   [int];
  logic [49:0] m_tag  [int];
  bit          m_vld  [SETS*WAYS];

  logic [63:0] last_rdata;
  logic [49:0] last_tag;
  logic [15:0] last_vld;

  function automatic int dkey(input int idx, input int way, input int word);
    return (idx * WAYS + way) * WORDS + word;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_rsp(input string tag, input int idx, input int way,
                           input int word, input int beat, input bit last);
    int k;
    logic [63:0] emask;
    logic [63:0] edata;
    logic [15:0] ev;
    k = dkey(idx, way, word);
    emask = '0;
    edata = '0;
    if (m_bm.exists(k)) begin
      for (int b = 0; b < 8; b++) if (m_bm[k][b]) emask[b*8 +: 8] = 8'hFF;
      edata = m_data[k];
    end
    last_rdata = rsp_rdata_o;
    last_tag   = rsp_tag_o;
    last_vld   = rsp_vld_way_o;
    chk({tag, ":valid"}, 64'(rsp_valid_o), 64'd1);
    chk({tag, ":data"}, rsp_rdata_o & emask, edata & emask);
    chk({tag, ":beat"}, 64'(rsp_beat_o), 64'(beat));
    chk({tag, ":last"}, 64'(rsp_last_o), 64'(last));
    for (int w = 0; w < WAYS; w++) ev[w] = m_vld[idx*WAYS + w];
    chk({tag, ":vld_way"}, 64'(rsp_vld_way_o), 64'(ev));
    for (int w = 0; w < WAYS; w++) begin
      if (m_tag.exists(idx*WAYS + w))
        chk({tag, ":flat_tag"}, 64'(rsp_tag_way_flat_o[w*TAG_W +: TAG_W]),
            64'(m_tag[idx*WAYS + w]));
    end
    if (m_tag.exists(idx*WAYS + way))
      chk({tag, ":tag"}, 64'(rsp_tag_o), 64'(m_tag[idx*WAYS + way]));
  endtask

  // Called at 1 time unit after a rising edge; returns 1 unit after the
  // accepting edge with the model updated.
  task automatic send(input logic [1:0] op, input int idx, input int way, input int word,
                      input logic [7:0] be, input logic [63:0] wd, input bit twe,
                      input logic [49:0] tg);
    int n;
    int k;
    logic [63:0] d;
    logic [7:0]  bm;
    req_op_i     = op;
    req_index_i  = IDX_W'(idx);
    req_way_i    = WAY_W'(way);
    req_word_i   = WSEL_W'(word);
    req_be_i     = be;
    req_wdata_i  = wd;
    req_tag_we_i = twe;
    req_tag_i    = tg;
    req_valid_i  = 1'b1;
    n = 0;
    @(negedge clk_i);
    while (!req_ready_o && n < 300) begin
      @(negedge clk_i);
      n++;
    end
    chk("req_accept", 64'(req_ready_o), 64'd1);
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
    if (op == OP_WR) begin
      k  = dkey(idx, way, word);
      d  = m_data.exists(k) ? m_data[k] : 64'd0;
      bm = m_bm.exists(k) ? m_bm[k] : 8'd0;
      for (int b = 0; b < 8; b++) begin
        if (be[b]) begin
          d[b*8 +: 8] = wd[b*8 +: 8];
          bm[b] = 1'b1;
        end
      end
      m_data[k] = d;
      m_bm[k]   = bm;
      if (twe) begin
        m_tag[idx*WAYS + way] = tg;
        m_vld[idx*WAYS + way] = 1'b1;
      end
    end else if (op == OP_INV) begin
      m_vld[idx*WAYS + way] = 1'b0;
    end
  endtask

  task automatic do_rd(input string tag, input int idx, input int way, input int word,
                       input int stall);
    int n;
    send(OP_RD, idx, way, word, 8'h00, 64'd0, 1'b0, 50'd0);
    rsp_ready_i = (stall == 0);
    n = 0;
    @(negedge clk_i);
    while (!rsp_valid_o && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    check_rsp(tag, idx, way, word, 0, 1'b1);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk_i);
      check_rsp({tag, ":held"}, idx, way, word, 0, 1'b1);
    end
    rsp_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_line(input string tag, input int idx, input int way, input bit toggle);
    int b;
    int cyc;
    send(OP_LINE, idx, way, 0, 8'h00, 64'd0, 1'b0, 50'd0);
    b = 0;
    cyc = 0;
    while (b < WORDS && cyc < 80) begin
      rsp_ready_i = toggle ? (cyc % 2 == 0) : 1'b1;
      @(negedge clk_i);
      if (rsp_valid_o) begin
        check_rsp(tag, idx, way, b, b, b == WORDS - 1);
        if (b < WORDS - 1) chk({tag, ":ready_in_burst"}, 64'(req_ready_o), 64'd0);
        if (rsp_ready_i) b++;
      end
      @(posedge clk_i);
      #1;
      cyc++;
    end
    chk({tag, ":beats"}, 64'(b), 64'(WORDS));
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    chk({tag, ":idle_after"}, 64'(req_ready_o), 64'd1);
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset_init(input string tag);
    int cnt;
    int rb;
    rst_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    chk({tag, ":rsp_valid"}, 64'(rsp_valid_o), 64'd0);
    chk({tag, ":rsp_last"}, 64'(rsp_last_o), 64'd0);
    chk({tag, ":rsp_rdata"}, rsp_rdata_o, 64'd0);
    chk({tag, ":busy"}, 64'(init_busy_o), 64'd1);
    chk({tag, ":ready"}, 64'(req_ready_o), 64'd0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    cnt = 0;
    rb  = 0;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk_i);
      if (!init_busy_o) break;
      cnt++;
      if (req_ready_o) rb++;
    end
    chk({tag, ":init_cycles"}, 64'(cnt), 64'd256);
    chk({tag, ":ready_during_init"}, 64'(rb), 64'd0);
    chk({tag, ":ready_after_init"}, 64'(req_ready_o), 64'd1);
    foreach (m_vld[i]) m_vld[i] = 1'b0;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    int n;
    int op;
    int idx;
    rst_i        = 1'b1;
    req_valid_i  = 1'b0;
    req_op_i     = 2'd0;
    req_index_i  = '0;
    req_way_i    = '0;
    req_word_i   = '0;
    req_be_i     = '0;
    req_wdata_i  = '0;
    req_tag_we_i = 1'b0;
    req_tag_i    = '0;
    rsp_ready_i  = 1'b1;
    @(posedge clk_i);
    #1;

    do_reset_init("rst0");
    do_rd("rd_empty", 16, 5, 2, 0);
    chk("rd_empty:vld5", 64'(last_vld[5]), 64'd0);

    send(OP_WR, 16, 5, 2, 8'hFF, 64'hDEADBEEFCAFEBABE, 1'b1, 50'h123456789ABC);
    do_rd("rd_wr", 16, 5, 2, 1);
    chk("rd_wr:const_data", last_rdata, 64'hDEADBEEFCAFEBABE);
    chk("rd_wr:const_tag", 64'(last_tag), 64'h123456789ABC);
    chk("rd_wr:vld5", 64'(last_vld[5]), 64'd1);

    send(OP_WR, 16, 5, 2, 8'h0F, 64'h0000000011111111, 1'b0, 50'd0);
    do_rd("rd_be", 16, 5, 2, 0);
    chk("rd_be:const_data", last_rdata, 64'hDEADBEEF11111111);

    for (int w = 0; w < WORDS; w++)
      send(OP_WR, 16, 3, w, 8'hFF, 64'(32'h100 + w), (w == 0), 50'h3333);
    do_line("line_toggle", 16, 3, 1'b1);

    send(OP_INV, 16, 5, 0, 8'h00, 64'd0, 1'b0, 50'd0);
    do_rd("rd_inv", 16, 5, 2, 0);
    chk("rd_inv:vld5", 64'(last_vld[5]), 64'd0);
    chk("rd_inv:const_tag", 64'(last_tag), 64'h123456789ABC);

    // Reset while beat 3 of a burst is on the output.
    send(OP_LINE, 16, 3, 0, 8'h00, 64'd0, 1'b0, 50'd0);
    rsp_ready_i = 1'b1;
    n = 0;
    @(negedge clk_i);
    while (!(rsp_valid_o && rsp_beat_o == 3'd3) && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    check_rsp("mid_burst", 16, 3, 3, 3, 1'b0);
    do_reset_init("rst_mid");
    do_rd("rd_after_rst", 16, 5, 2, 0);
    chk("rd_after_rst:const_data", last_rdata, 64'hDEADBEEF11111111);
    chk("rd_after_rst:vld5", 64'(last_vld[5]), 64'd0);

    // Randomised traffic over a few hot sets plus arbitrary ones.
    for (int i = 0; i < 80; i++) begin
      op = $urandom_range(0, 9);
      case ($urandom_range(0, 3))
        0: idx = 16;
        1: idx = 32;
        2: idx = 48;
        default: idx = $urandom_range(0, SETS - 1);
      endcase
      if (op < 4) begin
        do_rd("rnd_rd", idx, $urandom_range(0, WAYS - 1), $urandom_range(0, WORDS - 1),
              $urandom_range(0, 2));
      end else if (op < 8) begin
        send(OP_WR, idx, $urandom_range(0, WAYS - 1), $urandom_range(0, WORDS - 1),
             8'($urandom), {$urandom, $urandom}, 1'($urandom), {18'($urandom), $urandom});
      end else if (op == 8) begin
        send(OP_INV, idx, $urandom_range(0, WAYS - 1), 0, 8'h00, 64'd0, 1'b0, 50'd0);
      end else begin
        do_line("rnd_line", idx, $urandom_range(0, WAYS - 1), 1'($urandom));
      end
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk_i);
        #1;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rv64g_l2_arrays_burst.md
Name: rv64g_l2_arrays_burst

Overview:
Parametrised successor to the L2 data/tag arrays. It adds a valid/ready request and response handshake, per-way valid bits, a reset-time valid-clear sweep, and a full-line burst read mode for writeback and eviction. It sits between the L2 controller FSM and the storage, and replaces direct array strobes with a registered, back-pressurable interface.

Parameters:
SETS, 256, number of sets (power of 2); IDX_W = clog2(SETS)
WAYS, 16, associativity (power of 2); WAY_W = clog2(WAYS)
WORDS, 8, words per line (power of 2); WSEL_W = clog2(WORDS)
DATA_W, 64, word width (multiple of 8); BE_W = DATA_W/8
TAG_W, 50, tag width

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  synchronous reset, active-high
init_busy_o  out  1  valid-clear sweep in progress
req_valid_i  in  1  request valid
req_ready_o  out  1  request accepted when valid & ready
req_op_i  in  2  OP_RD=0, OP_WR=1, OP_LINE=2, OP_INV=3
req_index_i  in  IDX_W  set index
req_way_i  in  WAY_W  way select
req_word_i  in  WSEL_W  word select (RD/WR)
req_be_i  in  BE_W  byte enables (WR)
req_wdata_i  in  DATA_W  write data (WR)
req_tag_we_i  in  1  WR also writes tag and sets valid
req_tag_i  in  TAG_W  tag to write
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response consumed when valid & ready
rsp_rdata_o  out  DATA_W  selected word / burst beat
rsp_tag_o  out  TAG_W  tag of req_way_i
rsp_tag_way_flat_o  out  WAYS*TAG_W  all tags of set; way w at [w*TAG_W +: TAG_W]
rsp_vld_way_o  out  WAYS  valid bits of set
rsp_beat_o  out  WSEL_W  beat number (0 for RD)
rsp_last_o  out  1  final beat (1 for RD)

Behaviour:
- Reset (rst_i=1 at edge): state<=INIT, sweep counter<=0. rsp_valid_o=0, rsp_last_o=0, rsp_* data=0, req_ready_o=0, init_busy_o=1. Data/tag contents are NOT cleared.
- Reset mid-burst or mid-request: the in-flight response is dropped and the sweep restarts at set 0.
- INIT: clears valid bits of every way of set counter[IDX_W-1:0], one set per cycle, for exactly SETS cycles, then moves to IDLE. init_busy_o=1 throughout; deasserts on the first IDLE cycle.
- IDLE: req_ready_o = !rsp_valid_o | rsp_ready_i (single-entry output register; no bubble under continuous ready).
- OP_RD: response registered 1 cycle after accept. rdata is word req_word_i of way req_way_i; tag, flat tags and valid bits are for the set. beat=0, last=1.
- OP_WR: byte-masked data write on the accept edge. If req_tag_we_i=1, also writes the tag and sets valid. No response. be=0 with tag_we=0 is a no-op.
- OP_INV: clears the valid bit of (index, way). Tag and data are retained. No response.
- RAW ordering: an RD accepted the cycle after a WR/INV to the same location returns the updated value.
- OP_LINE: moves to BURST and latches index and way. Beats 0..WORDS-1 are issued one per cycle whenever the output slot is free (empty or being consumed). On rsp_ready_i=0 the beat and its data are held stable. last=1 on beat WORDS-1. req_ready_o=0 in BURST. Return to IDLE happens on the cycle the last beat is accepted by the output register, so the next request can be accepted the following cycle.
- rsp_valid_o, once high, holds until rsp_ready_i=1; response fields are stable while held.
- req_* inputs are ignored when req_ready_o=0.
- Out-of-range values cannot occur (power-of-2 parameters).

Decomposition:
- rv64g_l2_pkg holds: l2_arr_op_e encoding, default parameter constants, and the state enum {INIT, IDLE, BURST}.
- Sub-module rv64g_l2_way_ram: one way's data, tag and valid storage. Synchronous read, byte-masked write, valid clear/set ports. Instantiated WAYS times via generate.
- The top holds the FSM, sweep and beat counters, and the output register.

Test Plan:
- Reset, then count: init_busy_o is high for exactly 256 cycles and req_ready_o=0 meanwhile. Then issue RD at idx 0x10 way 5 -> rsp_vld_way_o=0.
- WR idx 0x10 word 2 way 5, be=0xFF, data 0xDEADBEEFCAFEBABE, tag_we=1, tag 0x123456789ABC. Then RD -> rdata=0xDEADBEEFCAFEBABE, rsp_tag_o=0x123456789ABC, flat[5*50+:50] matches, vld bit 5 set.
- WR be=0x0F, data 0x0000000011111111 to the same word, then immediate RD -> 0xDEADBEEF11111111.
- Fill words 0..7 of way 3 with 0x100+w, then OP_LINE with rsp_ready_i toggling 1,0,1,0 -> beats 0..7 in order, data 0x100..0x107, last only on beat 7, fields stable while stalled.
- OP_INV idx 0x10 way 5, then RD -> vld bit 5=0, tag still 0x123456789ABC.
- Assert rst_i at burst beat 3 -> rsp_valid_o=0 next cycle, sweep restarts, data at idx 0x10 word 2 is preserved after init.
